instr_encode_loader: RTL and testbench



---
 rtl/isa_pkg.sv | 62 ++++++
 rtl/instr_field_encoder.sv | 46 ++++
 rtl/instr_encode_loader.sv | 165 ++++++++++++++++
 tb/tb_instr_encode_loader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// ISA opcode map, instruction formats and field positions shared by the
// control decoder and the instruction encode/loader.
package isa_pkg;

    localparam logic [5:0] OP_J    = 6'd1;
    localparam logic [5:0] OP_MOV  = 6'd16;
    localparam logic [5:0] OP_NOT  = 6'd17;
    localparam logic [5:0] OP_ADD  = 6'd18;
    localparam logic [5:0] OP_SUB  = 6'd19;
    localparam logic [5:0] OP_AND  = 6'd20;
    localparam logic [5:0] OP_OR   = 6'd21;
    localparam logic [5:0] OP_XOR  = 6'd23;
    localparam logic [5:0] OP_BEQ  = 6'd32;
    localparam logic [5:0] OP_BNE  = 6'd33;
    localparam logic [5:0] OP_ADDI = 6'd50;
    localparam logic [5:0] OP_SUBI = 6'd51;
    localparam logic [5:0] OP_ANDI = 6'd52;
    localparam logic [5:0] OP_ORI  = 6'd53;
    localparam logic [5:0] OP_XORI = 6'd55;
    localparam logic [5:0] OP_LI   = 6'd57;
    localparam logic [5:0] OP_LWI  = 6'd59;
    localparam logic [5:0] OP_SWI  = 6'd60;

    typedef enum logic [2:0] {
        FMT_J,
        FMT_R,
        FMT_BR,
        FMT_I,
        FMT_ILLEGAL
    } fmt_e;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int FA_HI  = 25;
    localparam int FA_LO  = 21;
    localparam int FB_HI  = 20;
    localparam int FB_LO  = 16;
    localparam int FC_HI  = 15;
    localparam int FC_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int TGT_HI = 25;
    localparam int TGT_LO = 0;

    function automatic fmt_e op_fmt(input logic [5:0] op);
        fmt_e f;
        case (op)
            OP_J:    f = FMT_J;
            OP_MOV, OP_NOT, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_XOR:
                     f = FMT_R;
            OP_BEQ, OP_BNE:
                     f = FMT_BR;
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI,
            OP_XORI, OP_LI, OP_LWI, OP_SWI:
                     f = FMT_I;
            default: f = FMT_ILLEGAL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational field-bundle to instruction-word encoder.
// Fields a format does not use are left out of the word.
module instr_field_encoder
    import isa_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        word[OP_HI:OP_LO] = op;
        unique case (op_fmt(op))
            FMT_J: begin
                word[TGT_HI:TGT_LO] = target;
            end
            FMT_R: begin
                word[FA_HI:FA_LO] = rd;
                word[FB_HI:FB_LO] = rs;
                word[FC_HI:FC_LO] = rt;
            end
            FMT_BR: begin
                word[FA_HI:FA_LO]   = rs;
                word[FB_HI:FB_LO]   = rt;
                word[IMM_HI:IMM_LO] = imm;
            end
            FMT_I: begin
                word[FA_HI:FA_LO]   = rd;
                word[FB_HI:FB_LO]   = rs;
                word[IMM_HI:IMM_LO] = imm;
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes field bundles and writes them sequentially into IMem.
// Optional running XOR checksum output: INSTR_LOADER_CHECKSUM_EN.
module instr_encode_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [5:0]        op_code,
    input  logic [4:0]        op_rd,
    input  logic [4:0]        op_rs,
    input  logic [4:0]        op_rt,
    input  logic [15:0]       op_imm,
    input  logic [25:0]       op_target,
    input  logic              op_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic              err_sticky,
`ifdef INSTR_LOADER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic [ADDR_W:0]   count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_DONE,
        S_FULL
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP  = '1;

    state_t             state;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [5:0]         c_code;
    logic [4:0]         c_rd;
    logic [4:0]         c_rs;
    logic [4:0]         c_rt;
    logic [15:0]        c_imm;
    logic [25:0]        c_tgt;
    logic               c_last;
    logic [31:0]        enc_word;
    logic               enc_legal;

    instr_field_encoder u_enc (
        .op     (c_code),
        .rd     (c_rd),
        .rs     (c_rs),
        .rt     (c_rt),
        .imm    (c_imm),
        .target (c_tgt),
        .word   (enc_word),
        .legal  (enc_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wr_ptr     <= BASE;
            count      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE;
            mem_wdata  <= '0;
            done       <= 1'b0;
            full       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            op_ready   <= 1'b0;
            c_code     <= '0;
            c_rd       <= '0;
            c_rs       <= '0;
            c_rt       <= '0;
            c_imm      <= '0;
            c_tgt      <= '0;
            c_last     <= 1'b0;
        end else if (start) begin
            state      <= S_IDLE;
            wr_ptr     <= BASE;
            count      <= '0;
            mem_we     <= 1'b0;
            done       <= 1'b0;
            full       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            op_ready   <= 1'b1;
        end else begin
            err    <= 1'b0;
            mem_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (op_valid && op_ready) begin
                        c_code   <= op_code;
                        c_rd     <= op_rd;
                        c_rs     <= op_rs;
                        c_rt     <= op_rt;
                        c_imm    <= op_imm;
                        c_tgt    <= op_target;
                        c_last   <= op_last;
                        op_ready <= 1'b0;
                        state    <= S_CHECK;
                    end else begin
                        op_ready <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (enc_legal) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        mem_wdata <= enc_word;
                        state     <= S_WRITE;
                    end else begin
                        err        <= 1'b1;
                        err_sticky <= 1'b1;
                        op_ready   <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    count  <= count + (ADDR_W+1)'(1);
                    if (wr_ptr == TOP)
                        full <= 1'b1;
                    // A final bundle landing in the top slot ends in DONE
                    if (c_last) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (wr_ptr == TOP) begin
                        state <= S_FULL;
                    end else begin
                        op_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                S_DONE, S_FULL: begin
                    op_ready <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || start)
            checksum <= '0;
        else if (mem_we)
            checksum <= checksum ^ mem_wdata;
    end
`endif

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader (ADDR_W=2 to reach FULL).
module tb_instr_encode_loader;

    localparam int AW = 2;

    typedef struct {
        logic [5:0]  code;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          op_valid;
    logic          op_ready;
    logic [5:0]    op_code;
    logic [4:0]    op_rd;
    logic [4:0]    op_rs;
    logic [4:0]    op_rt;
    logic [15:0]   op_imm;
    logic [25:0]   op_target;
    logic          op_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          done;
    logic          full;
    logic          err;
    logic          err_sticky;
    logic [AW:0]   count;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    int            n_checks;
    int            n_fail;
    int            err_seen;
    wr_t           sb[$];
    logic [AW-1:0] exp_ptr;
    vec_t          vt[12];

    instr_encode_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_rd      (op_rd),
        .op_rs      (op_rs),
        .op_rt      (op_rt),
        .op_imm     (op_imm),
        .op_target  (op_target),
        .op_last    (op_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .done       (done),
        .full       (full),
        .err        (err),
        .err_sticky (err_sticky),
`ifdef INSTR_LOADER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (err === 1'b1)
            err_seen++;
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic drive(input vec_t v, input logic last);
        op_code   = v.code;
        op_rd     = v.rd;
        op_rs     = v.rs;
        op_rt     = v.rt;
        op_imm    = v.imm;
        op_target = v.tgt;
        op_last   = last;
    endtask

    task automatic send(input vec_t v, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        while (op_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (op_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_ready_timeout: got 0 expected 1");
        end else begin
            drive(v, last);
            op_valid = 1'b1;
            if (v.legal) begin
                sb.push_back('{addr: exp_ptr, data: v.word});
                exp_ptr = exp_ptr + 1'b1;
            end
            @(posedge clk);
            #1 op_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start    = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        exp_ptr = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t add_v, j_v, addi_v;
        int   e0;
        n_checks = 0;
        n_fail   = 0;
        err_seen = 0;
        exp_ptr  = '0;
        reset    = 1'b1;
        start    = 1'b0;
        op_valid = 1'b0;
        op_code  = '0; op_rd = '0; op_rs = '0; op_rt = '0;
        op_imm   = '0; op_target = '0; op_last = 1'b0;

        vt[0]  = '{6'd18, 5'd3,  5'd1, 5'd2,  16'h0000, 26'h0,       1'b1, 32'h48611000};
        vt[1]  = '{6'd32, 5'd0,  5'd1, 5'd2,  16'h0003, 26'h0,       1'b1, 32'h80220003};
        vt[2]  = '{6'd22, 5'd3,  5'd1, 5'd2,  16'h0000, 26'h0,       1'b0, 32'h0};
        vt[3]  = '{6'd1,  5'd5,  5'd6, 5'd7,  16'h1111, 26'h3FFFFFF, 1'b1, 32'h07FFFFFF};
        vt[4]  = '{6'd60, 5'd31, 5'd0, 5'd31, 16'h1234, 26'h2AAAAAA, 1'b1, 32'hF3E01234};
        vt[5]  = '{6'd23, 5'd1,  5'd2, 5'd3,  16'hFFFF, 26'h155,     1'b1, 32'h5C221800};
        vt[6]  = '{6'd33, 5'd9,  5'd7, 5'd8,  16'h8000, 26'h1,       1'b1, 32'h84E88000};
        vt[7]  = '{6'd57, 5'd2,  5'd0, 5'd4,  16'hABCD, 26'h3,       1'b1, 32'hE440ABCD};
        vt[8]  = '{6'd0,  5'd1,  5'd1, 5'd1,  16'h0001, 26'h1,       1'b0, 32'h0};
        vt[9]  = '{6'd63, 5'd1,  5'd1, 5'd1,  16'h0001, 26'h1,       1'b0, 32'h0};
        vt[10] = '{6'd54, 5'd1,  5'd1, 5'd1,  16'h0001, 26'h1,       1'b0, 32'h0};
        vt[11] = '{6'd34, 5'd1,  5'd1, 5'd1,  16'h0001, 26'h1,       1'b0, 32'h0};
        add_v  = vt[0];
        j_v    = '{6'd1,  5'd0, 5'd0, 5'd0, 16'h0,    26'h40, 1'b1, 32'h04000040};
        addi_v = '{6'd50, 5'd5, 5'd4, 5'd0, 16'hFFFF, 26'h0,  1'b1, 32'hC8A4FFFF};

        repeat (2) @(negedge clk);
        check("rst_mem_we",     32'(mem_we), 0);
        check("rst_op_ready",   32'(op_ready), 0);
        check("rst_count",      32'(count), 0);
        check("rst_mem_addr",   32'(mem_addr), 0);
        check("rst_mem_wdata",  mem_wdata, 0);
        check("rst_done",       32'(done), 0);
        check("rst_full",       32'(full), 0);
        check("rst_err",        32'(err), 0);
        check("rst_err_sticky", 32'(err_sticky), 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            pulse_start();
            e0 = err_seen;
            send(vt[i], 1'b0);
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_count", i), 32'(count),
                  vt[i].legal ? 32'd1 : 32'd0);
            check($sformatf("v%0d_err_sticky", i), 32'(err_sticky),
                  vt[i].legal ? 32'd0 : 32'd1);
            check($sformatf("v%0d_err_pulses", i), 32'(err_seen - e0),
                  vt[i].legal ? 32'd0 : 32'd1);
            check($sformatf("v%0d_op_ready", i), 32'(op_ready), 1);
        end

        pulse_start();
        send(j_v, 1'b0);
        send(addi_v, 1'b1);
        repeat (4) @(negedge clk);
        check("last_done",     32'(done), 1);
        check("last_op_ready", 32'(op_ready), 0);
        check("last_count",    32'(count), 2);
        drive(add_v, 1'b0);
        op_valid = 1'b1;
        repeat (5) @(negedge clk);
        op_valid = 1'b0;
        check("done_hold", 32'(done), 1);
        check("done_count_hold", 32'(count), 2);

        pulse_start();
        check("start_clr_done", 32'(done), 0);
        check("start_clr_count", 32'(count), 0);
        for (int i = 0; i < 4; i++)
            send(add_v, 1'b0);
        repeat (4) @(negedge clk);
        check("full_flag",  32'(full), 1);
        check("full_count", 32'(count), 4);
        drive(j_v, 1'b0);
        op_valid = 1'b1;
        repeat (8) @(negedge clk);
        check("full_op_ready", 32'(op_ready), 0);
        check("full_hold",     32'(full), 1);
        check("full_no_done",  32'(done), 0);
        check("full_count_hold", 32'(count), 4);
        pulse_start();
        check("start_clr_full", 32'(full), 0);
        send(j_v, 1'b0);
        repeat (4) @(negedge clk);
        check("after_full_count", 32'(count), 1);

        pulse_start();
        for (int i = 0; i < 3; i++)
            send(addi_v, 1'b0);
        send(add_v, 1'b1);
        repeat (4) @(negedge clk);
        check("edge_done", 32'(done), 1);
        check("edge_full", 32'(full), 1);

        pulse_start();
        @(negedge clk);
        drive(add_v, 1'b0);
        start    = 1'b1;
        op_valid = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("start_wins_count", 32'(count), 0);
        check("start_wins_ready", 32'(op_ready), 1);

        pulse_start();
        send(add_v, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rw_mem_we_in_write", 32'(mem_we), 1);
        reset = 1'b1;
        @(negedge clk);
        check("rw_mem_we", 32'(mem_we), 0);
        check("rw_count",  32'(count), 0);
        reset   = 1'b0;
        exp_ptr = '0;
        repeat (2) @(negedge clk);
        check("rw_idle_ready", 32'(op_ready), 1);
        check("rw_count_hold", 32'(count), 0);

`ifdef INSTR_LOADER_CHECKSUM_EN
        pulse_start();
        check("cs_cleared", checksum, 0);
        send(add_v, 1'b0);
        send(j_v, 1'b0);
        repeat (4) @(negedge clk);
        check("cs_value", checksum, 32'h4C611040);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
